// File: rtl/des_pkg.sv
// Shared DES round constants: expansion/permutation tables, S-box contents and helpers.
// A table entry n selects source bit [W-n], so DES bit 1 is always the MSB.
package des_pkg;

  localparam int unsigned HALF_W = 32;
  localparam int unsigned KEY_W  = 48;
  localparam int unsigned SBOX_N = 8;

  typedef logic [HALF_W-1:0] half_t;
  typedef logic [KEY_W-1:0]  key_t;

  localparam int unsigned E_TAB [KEY_W] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1
  };

  localparam int unsigned P_TAB [HALF_W] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
  };

  // Each box: four 16-nibble rows, row 0 column 0 in the top nibble.
  localparam logic [255:0] SBOX_TAB [SBOX_N] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  function automatic key_t des_expand(input half_t r);
    key_t e;
    e = '0;
    for (int unsigned i = 0; i < KEY_W; i++) e[KEY_W-1-i] = r[HALF_W-E_TAB[i]];
    return e;
  endfunction

  function automatic half_t des_perm_p(input half_t s);
    half_t p;
    p = '0;
    for (int unsigned i = 0; i < HALF_W; i++) p[HALF_W-1-i] = s[HALF_W-P_TAB[i]];
    return p;
  endfunction

endpackage

// File: rtl/des_sbox_bank.sv
// The eight S-boxes side by side: 48-bit address in, 32-bit substitution out, purely combinational.
module des_sbox_bank
  import des_pkg::*;
(
  input  key_t  addr_i,
  output half_t data_o
);

  des_sbox_rom #(.BOX(0)) S1_ROM (.addr_i(addr_i[47:42]), .data_o(data_o[31:28]));
  des_sbox_rom #(.BOX(1)) S2_ROM (.addr_i(addr_i[41:36]), .data_o(data_o[27:24]));
  des_sbox_rom #(.BOX(2)) S3_ROM (.addr_i(addr_i[35:30]), .data_o(data_o[23:20]));
  des_sbox_rom #(.BOX(3)) S4_ROM (.addr_i(addr_i[29:24]), .data_o(data_o[19:16]));
  des_sbox_rom #(.BOX(4)) S5_ROM (.addr_i(addr_i[23:18]), .data_o(data_o[15:12]));
  des_sbox_rom #(.BOX(5)) S6_ROM (.addr_i(addr_i[17:12]), .data_o(data_o[11:8]));
  des_sbox_rom #(.BOX(6)) S7_ROM (.addr_i(addr_i[11:6]),  .data_o(data_o[7:4]));
  des_sbox_rom #(.BOX(7)) S8_ROM (.addr_i(addr_i[5:0]),   .data_o(data_o[3:0]));

endmodule

// File: rtl/des_sbox_rom.sv
// One DES S-box as a 64x4 ROM; BOX selects which of the eight tables.
module des_sbox_rom
  import des_pkg::*;
#(
  parameter int unsigned BOX = 0
) (
  input  logic [5:0] addr_i,
  output logic [3:0] data_o
);

  logic [5:0] idx;

  // Outer address bits pick the row, inner four the column; ~idx counts nibbles from the LSB.
  always_comb begin
    idx    = {addr_i[5], addr_i[0], addr_i[4:1]};
    data_o = SBOX_TAB[BOX][{~idx, 2'b00} +: 4];
  end

endmodule

// File: rtl/des_feistel_round.sv
// Two-stage pipelined DES Feistel round with valid/ready on both sides.
// Stage 1 registers E(R)^K and the halves; stage 2 registers the (optionally swapped) result.
module des_feistel_round
  import des_pkg::*;
#(
  parameter bit SWAP_OUT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_l,
  input  logic [31:0] in_r,
  input  logic [47:0] in_key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_l,
  output logic [31:0] out_r
);

  logic  s1_v_q, s2_v_q;
  logic  s1_adv, s2_adv;
  key_t  s1_addr_q, s1_addr_d;
  half_t s1_l_q, s1_r_q;
  half_t out_l_q, out_l_d, out_r_q, out_r_d;
  half_t sbo, f, l_xor_f;

  always_comb begin
    s2_adv    = !s2_v_q || out_ready;
    s1_adv    = !s1_v_q || s2_adv;
    s1_addr_d = des_expand(in_r) ^ in_key;
  end

  des_sbox_bank u_sbox_bank (
    .addr_i (s1_addr_q),
    .data_o (sbo)
  );

  always_comb begin
    f       = des_perm_p(sbo);
    l_xor_f = s1_l_q ^ f;
    if (SWAP_OUT) begin
      out_l_d = s1_r_q;
      out_r_d = l_xor_f;
    end else begin
      out_l_d = l_xor_f;
      out_r_d = s1_r_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q    <= 1'b0;
      s1_addr_q <= '0;
      s1_l_q    <= '0;
      s1_r_q    <= '0;
    end else if (s1_adv) begin
      s1_v_q <= in_valid;
      if (in_valid) begin
        s1_addr_q <= s1_addr_d;
        s1_l_q    <= in_l;
        s1_r_q    <= in_r;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v_q  <= 1'b0;
      out_l_q <= '0;
      out_r_q <= '0;
    end else if (s2_adv) begin
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        out_l_q <= out_l_d;
        out_r_q <= out_r_d;
      end
    end
  end

  assign in_ready  = s1_adv;
  assign out_valid = s2_v_q;
  assign out_l     = out_l_q;
  assign out_r     = out_r_q;

endmodule

// File: tb/tb_des_feistel_round.sv
// Bench for des_feistel_round: both SWAP_OUT variants share stimulus and are checked
// every cycle against a transaction-level DES round model and an in-flight queue.
module tb_des_feistel_round;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_l, in_r;
  logic [47:0] in_key;
  logic        out_ready;
  logic        in_ready_sw, out_valid_sw, in_ready_ns, out_valid_ns;
  logic [31:0] out_l_sw, out_r_sw, out_l_ns, out_r_ns;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  des_feistel_round #(.SWAP_OUT(1'b1)) u_dut_sw (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_sw),
    .in_l(in_l), .in_r(in_r), .in_key(in_key),
    .out_valid(out_valid_sw), .out_ready(out_ready), .out_l(out_l_sw), .out_r(out_r_sw)
  );

  des_feistel_round #(.SWAP_OUT(1'b0)) u_dut_ns (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_ns),
    .in_l(in_l), .in_r(in_r), .in_key(in_key),
    .out_valid(out_valid_ns), .out_ready(out_ready), .out_l(out_l_ns), .out_r(out_r_ns)
  );

  // ---------------- reference DES round, in FIPS bit numbering ----------------
  localparam int EM [48] = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                             16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
  localparam int PM [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                             2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
  localparam int SB [8][4][16] = '{
    '{'{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7}, '{0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8},
      '{4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0}, '{15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13}},
    '{'{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10}, '{3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5},
      '{0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15}, '{13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9}},
    '{'{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8}, '{13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1},
      '{13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7}, '{1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12}},
    '{'{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15}, '{13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9},
      '{10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4}, '{3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14}},
    '{'{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9}, '{14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6},
      '{4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14}, '{11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3}},
    '{'{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11}, '{10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8},
      '{9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6}, '{4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13}},
    '{'{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1}, '{13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6},
      '{1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2}, '{6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12}},
    '{'{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7}, '{1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2},
      '{7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8}, '{2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}}
  };

  function automatic logic [47:0] m_ek(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] e;
    for (int n = 1; n <= 48; n++) e[48-n] = r[32-EM[n-1]];
    return e ^ k;
  endfunction

  function automatic logic [31:0] m_sbo(input logic [47:0] x);
    logic [31:0] s;
    logic [5:0]  c;
    for (int j = 0; j < 8; j++) begin
      c = x[47-6*j -: 6];
      s[31-4*j -: 4] = 4'(SB[j][{c[5], c[0]}][c[4:1]]);
    end
    return s;
  endfunction

  function automatic logic [31:0] m_perm(input logic [31:0] s);
    logic [31:0] p;
    for (int n = 1; n <= 32; n++) p[32-n] = s[32-PM[n-1]];
    return p;
  endfunction

  function automatic logic [31:0] m_f(input logic [31:0] r, input logic [47:0] k);
    return m_perm(m_sbo(m_ek(r, k)));
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction scoreboard ----------------
  typedef struct {
    logic [31:0] a;    // R passes through
    logic [31:0] b;    // L ^ f
    int          age;  // clock edges since acceptance
  } item_t;

  item_t q[$];
  bit    push_p, pop_p;
  item_t new_p;

  always @(negedge clk) begin
    bit exp_v, exp_rdy;
    push_p = 1'b0;
    pop_p  = 1'b0;
    if (!rst) begin
      exp_v   = (q.size() > 0) && (q[0].age >= 2);
      exp_rdy = (q.size() < 2) || out_ready;
      check("in_ready_sw", 64'(in_ready_sw), 64'(exp_rdy));
      check("in_ready_ns", 64'(in_ready_ns), 64'(exp_rdy));
      check("out_valid_sw", 64'(out_valid_sw), 64'(exp_v));
      check("out_valid_ns", 64'(out_valid_ns), 64'(exp_v));
      if (exp_v) begin
        check("out_sw", {out_l_sw, out_r_sw}, {q[0].a, q[0].b});
        check("out_ns", {out_l_ns, out_r_ns}, {q[0].b, q[0].a});
      end
      pop_p  = exp_v && out_ready;
      push_p = in_valid && exp_rdy;
      new_p  = '{a: in_r, b: in_l ^ m_f(in_r, in_key), age: 0};
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
    end else begin
      if (pop_p) void'(q.pop_front());
      if (push_p) q.push_back(new_p);
      foreach (q[i]) q[i].age++;
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] n = '0;
  bit          last_fire = 1'b0;
  bit          rnd_data = 1'b0;

  task automatic gen_next();
    n++;
    if (rnd_data) begin
      in_l   = $urandom;
      in_r   = $urandom;
      in_key = {16'($urandom), 32'($urandom)};
    end else begin
      in_l   = n * 32'h9E3779B9;
      in_r   = {n[7:0], ~n[7:0], n[15:0]} ^ 32'h5A5A3C3C;
      in_key = {in_l[15:0], in_r} ^ 48'hF0F01234ABCD;
    end
  endtask

  // Called at posedge+1; a pending unaccepted input is held until it transfers.
  task automatic step(input bit want_v, input bit ordy);
    if (!in_valid || last_fire) begin
      in_valid = want_v;
      if (want_v) gen_next();
    end
    out_ready = ordy;
    @(negedge clk);
    last_fire = in_valid && in_ready_sw;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", vectors);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_l = '0; in_r = '0; in_key = '0; out_ready = 1'b1;
    #3;
    check("rst_out_valid", 64'({out_valid_sw, out_valid_ns}), 64'd0);
    check("rst_in_ready", 64'({in_ready_sw, in_ready_ns}), 64'b11);
    check("rst_out", {out_l_sw, out_r_sw}, 64'd0);
    @(negedge clk); #2 rst = 1'b0;

    // Pin the model itself against the FIPS round-1 values.
    check("model_ek", 64'(m_ek(32'hF0AAF0AA, 48'h1B02EFFC7072)), 64'h6117BA866527);
    check("model_sbo", 64'(m_sbo(48'h6117BA866527)), 64'h5C82B597);
    check("model_f", 64'(m_f(32'hF0AAF0AA, 48'h1B02EFFC7072)), 64'h234AA9BB);

    // FIPS round-1 vector through both variants.
    @(posedge clk); #1;
    in_valid = 1'b1; in_l = 32'hCC00CCFF; in_r = 32'hF0AAF0AA; in_key = 48'h1B02EFFC7072;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("t1_s1_addr", 64'(u_dut_sw.s1_addr_q), 64'h6117BA866527);
    check("t1_sbo", 64'(u_dut_sw.sbo), 64'h5C82B597);
    @(negedge clk);
    check("t1_out_sw", {out_l_sw, out_r_sw}, 64'hF0AAF0AA_EF4A6544);
    check("t1_out_ns", {out_l_ns, out_r_ns}, 64'hEF4A6544_F0AAF0AA);
    @(posedge clk); #1;
    last_fire = 1'b0;
    step(0, 1); step(0, 1);

    // Streaming at full rate.
    for (int i = 0; i < 16; i++) begin
      check("stream_in_ready", 64'(in_ready_sw), 64'd1);
      check("stream_out_valid", 64'(out_valid_sw), 64'(i >= 2));
      step(1, 1);
    end
    for (int i = 0; i < 4; i++) step(0, 1);

    // Back-pressure: five stalled cycles while still offering input.
    for (int i = 0; i < 5; i++) step(1, 0);
    check("bp_in_ready", 64'(in_ready_sw), 64'd0);
    for (int i = 0; i < 8; i++) step(1, 1);
    for (int i = 0; i < 4; i++) step(0, 1);

    // Asynchronous reset with both stages full.
    for (int i = 0; i < 3; i++) step(1, 0);
    @(negedge clk); #2 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 64'({out_valid_sw, out_valid_ns}), 64'd0);
    check("mid_rst_out", {out_l_sw, out_r_sw}, 64'd0);
    check("mid_rst_in_ready", 64'({in_ready_sw, in_ready_ns}), 64'b11);
    in_valid = 1'b0; last_fire = 1'b0; out_ready = 1'b1;
    @(negedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;
    step(1, 1);
    check("post_rst_lat1", 64'(out_valid_sw), 64'd0);
    step(0, 1);
    check("post_rst_lat2", 64'(out_valid_sw), 64'd1);
    step(0, 1);

    // Random bubbles on both sides.
    rnd_data = 1'b1;
    for (int i = 0; i < 10000; i++) step(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
    for (int i = 0; i < 6; i++) step(0, 1);
    check("drain_empty", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
